cp_remove: RTL

//  Consumes the sample stream produced by the synchronization stage (frame start on s_user, end on s_last).

---
 rtl/wiphy_pkg.sv | 25 ++
 rtl/cp_remove.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/wiphy_pkg.sv
// wiphy_pkg
//   Shared types and default dimensions for the OFDM receive chain.
//   sample_t   : packed complex sample {q, i}, 16-bit signed each
//   cp_state_t : cyclic-prefix remover states
//   DEFAULT_*  : default symbol / guard / sample dimensions
package wiphy_pkg;

    localparam int DEFAULT_FFT_LEN      = 64;
    localparam int DEFAULT_CP_LEN       = 16;
    localparam int DEFAULT_FIRST_CP_LEN = 32;
    localparam int DEFAULT_DATA_W       = 32;

    typedef struct packed {
        logic signed [15:0] q;
        logic signed [15:0] i;
    } sample_t;

    typedef enum logic [1:0] {
        IDLE,
        CP,
        BODY,
        PAD
    } cp_state_t;

endpackage

// File: rtl/cp_remove.sv
// cp_remove
//   Strips the cyclic prefix from the synchronized OFDM sample stream and
//   emits FFT_LEN-sample symbol bodies with symbol and packet framing.
//   Sample data passes through bit-exact.
//
// Ports
//   clk      in   clock, sole domain
//   reset    in   synchronous active-high reset
//   s_valid  in   upstream sample valid
//   s_ready  out  upstream ready
//   s_data   in   upstream sample {q,i}
//   s_user   in   first sample of packet (first guard sample)
//   s_last   in   last sample of packet
//   m_valid  out  output valid
//   m_ready  in   downstream ready
//   m_data   out  symbol-body sample (zero while padding)
//   m_user   out  first sample of first symbol of packet
//   m_last   out  last sample of every symbol
//   m_eop    out  qualifies m_last: final symbol of packet
//   sym_count out 16  symbols completed (only with CP_REMOVE_STATS_EN)
//   pad_count out 16  PAD entries       (only with CP_REMOVE_STATS_EN)
//
// Build option
//   CP_REMOVE_STATS_EN : adds the sym_count / pad_count statistics ports.
module cp_remove
    import wiphy_pkg::*;
#(
    parameter int FFT_LEN      = DEFAULT_FFT_LEN,
    parameter int CP_LEN       = DEFAULT_CP_LEN,
    parameter int FIRST_CP_LEN = DEFAULT_FIRST_CP_LEN,
    parameter int DATA_W       = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_user,
    input  logic              s_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_user,
    output logic              m_last,
    output logic              m_eop
`ifdef CP_REMOVE_STATS_EN
    ,
    output logic [15:0]       sym_count,
    output logic [15:0]       pad_count
`endif
);

    localparam int MAX_LEN = (FIRST_CP_LEN > FFT_LEN) ? FIRST_CP_LEN : FFT_LEN;
    localparam int CNT_W   = $clog2(MAX_LEN);

    typedef logic [CNT_W-1:0] cnt_t;

    cp_state_t         state_q, state_d;
    cnt_t              guard_q, guard_d;
    cnt_t              idx_q, idx_d;
    logic              first_q, first_d;
    logic              m_valid_q, m_valid_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic              m_user_q, m_user_d;
    logic              m_last_q, m_last_d;
    logic              m_eop_q, m_eop_d;

    logic slot_free;
    logic last_idx;
    logic guard_done;
    logic resync;

    assign slot_free  = !m_valid_q || m_ready;
    assign last_idx   = (idx_q == cnt_t'(FFT_LEN - 1));
    // guard_q holds the number of guard samples already seen, so the
    // sample arriving with guard_q == len-1 is the final guard sample.
    assign guard_done = first_q ? (guard_q == cnt_t'(FIRST_CP_LEN - 1))
                                : (guard_q == cnt_t'(CP_LEN - 1));
    // s_user together with s_last counts as an end of packet, not a resync.
    assign resync     = s_valid && s_user && !s_last;

    // Next-state, counter and output-slice logic. The output slice is
    // refilled only when it is empty or being drained this cycle.
    always_comb begin
        state_d   = state_q;
        guard_d   = guard_q;
        idx_d     = idx_q;
        first_d   = first_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_user_d  = m_user_q;
        m_last_d  = m_last_q;
        m_eop_d   = m_eop_q;
        s_ready   = 1'b0;

        if (slot_free) begin
            m_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                s_ready = 1'b1;
                if (resync) begin
                    state_d = CP;
                    guard_d = cnt_t'(1);
                    first_d = 1'b1;
                end
            end

            CP: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    if (s_last) begin
                        state_d = IDLE;
                    end else if (s_user) begin
                        guard_d = cnt_t'(1);
                        first_d = 1'b1;
                    end else if (guard_done) begin
                        state_d = BODY;
                        idx_d   = '0;
                    end else begin
                        guard_d = guard_q + cnt_t'(1);
                    end
                end
            end

            BODY: begin
                // A new packet start is held off so it can be replayed as
                // guard 0 once the open symbol has been padded out.
                s_ready = slot_free && !(s_user && !s_last);
                if (resync) begin
                    state_d = PAD;
                end else if (s_valid && slot_free) begin
                    m_valid_d = 1'b1;
                    m_data_d  = s_data;
                    m_user_d  = first_q && (idx_q == '0);
                    m_last_d  = last_idx;
                    m_eop_d   = last_idx && s_last;
                    idx_d     = idx_q + cnt_t'(1);
                    first_d   = 1'b0;
                    if (last_idx) begin
                        state_d = s_last ? IDLE : CP;
                        guard_d = '0;
                    end else if (s_last) begin
                        state_d = PAD;
                    end
                end
            end

            PAD: begin
                if (slot_free) begin
                    m_valid_d = 1'b1;
                    m_data_d  = '0;
                    m_user_d  = first_q && (idx_q == '0);
                    m_last_d  = last_idx;
                    m_eop_d   = last_idx;
                    idx_d     = idx_q + cnt_t'(1);
                    if (last_idx) begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and output slice; reset discards any partial symbol.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            guard_q   <= '0;
            idx_q     <= '0;
            first_q   <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_user_q  <= 1'b0;
            m_last_q  <= 1'b0;
            m_eop_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            guard_q   <= guard_d;
            idx_q     <= idx_d;
            first_q   <= first_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_user_q  <= m_user_d;
            m_last_q  <= m_last_d;
            m_eop_q   <= m_eop_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_user  = m_user_q;
    assign m_last  = m_last_q;
    assign m_eop   = m_eop_q;

`ifdef CP_REMOVE_STATS_EN
    logic [15:0] sym_count_q;
    logic [15:0] pad_count_q;

    // Wrapping statistics: completed symbols leave on an m_last transfer,
    // and a PAD entry is any transition into PAD from another state.
    always_ff @(posedge clk) begin
        if (reset) begin
            sym_count_q <= '0;
            pad_count_q <= '0;
        end else begin
            if (m_valid_q && m_ready && m_last_q) begin
                sym_count_q <= sym_count_q + 16'd1;
            end
            if ((state_d == PAD) && (state_q != PAD)) begin
                pad_count_q <= pad_count_q + 16'd1;
            end
        end
    end

    assign sym_count = sym_count_q;
    assign pad_count = pad_count_q;
`endif

endmodule
